// File: rtl/pic_irr_priority.sv
// pic_irr_priority: IR synchronisers, IRR latch (edge/level), priority
// resolver with rotation, two-pulse INTA sequencer and EOI handling for an
// 8259-style PIC.
// Optional feature macro: PIC_SPECIAL_MASK_EN (special mask mode via smm).
module pic_irr_priority #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] ir,
   input  logic       ltim,
   input  logic [7:0] mask,
   input  logic       aeoi,
   input  logic       rot,
   input  logic       eoi,
   input  logic       eoi_spec,
   input  logic [2:0] eoi_lvl,
   input  logic       setpri,
   input  logic       smm,
   input  logic       inta_n,
   output logic [7:0] irr,
   output logic [7:0] isr,
   output logic       int_req,
   output logic [2:0] vec_lvl,
   output logic       ack_busy
);

   typedef enum logic [0:0] {ST_IDLE, ST_ACK1} ack_state_e;

   logic [7:0]             ir_sync_q [SYNC_STAGES];
   logic [7:0]             ir_sync_d [SYNC_STAGES];
   logic [SYNC_STAGES-1:0] inta_sync_q, inta_sync_d;
   logic [7:0]             ir_prev_q, ir_prev_d;
   logic                   inta_prev_q, inta_prev_d;
   logic [7:0]             irr_q, irr_d;
   logic [7:0]             isr_q, isr_d;
   logic                   int_req_q, int_req_d;
   logic [2:0]             vec_lvl_q, vec_lvl_d;
   logic [2:0]             lowest_q, lowest_d;
   ack_state_e             state_q, state_d;

   logic [7:0] ir_s, ir_rise;
   logic       inta_s, inta_fall;
   logic       smm_act;
   logic [7:0] cand_vec, eoi_vec, isr_set;
   logic [3:0] cand_rank, isr_rank, eoi_rank;
   logic [2:0] cand_lvl, eoi_ns_lvl;

`ifdef PIC_SPECIAL_MASK_EN
   assign smm_act = smm;
`else
   assign smm_act = smm & 1'b0;
`endif

   // Rank of the highest-priority set bit (0 = highest), 8 when none set.
   // Rank 0 is level (low+1) mod 8, descending cyclically from there.
   function automatic logic [3:0] pri_rank(input logic [7:0] v, input logic [2:0] low);
      logic [2:0] idx;
      pri_rank = 4'd8;
      for (int unsigned i = 8; i > 0; i--) begin
         idx = low + 3'd1 + 3'(i - 1);
         if (v[idx]) pri_rank = 4'(i - 1);
      end
   endfunction

   function automatic logic [2:0] rank_lvl(input logic [2:0] rank, input logic [2:0] low);
      rank_lvl = low + 3'd1 + rank;
   endfunction

   // Synchroniser chains: index 0 samples the raw input.
   always_comb begin
      ir_sync_d[0] = ir;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) ir_sync_d[i] = ir_sync_q[i-1];
      inta_sync_d = {inta_sync_q[SYNC_STAGES-2:0], inta_n};
      ir_s        = ir_sync_q[SYNC_STAGES-1];
      inta_s      = inta_sync_q[SYNC_STAGES-1];
      ir_prev_d   = ir_s;
      inta_prev_d = inta_s;
      ir_rise     = ir_s & ~ir_prev_q;
      inta_fall   = ~inta_s & inta_prev_q;
   end

   // Priority resolution on the registered (pre-update) state.
   always_comb begin
      cand_vec   = smm_act ? (irr_q & ~mask & ~isr_q) : (irr_q & ~mask);
      eoi_vec    = smm_act ? (isr_q & ~mask) : isr_q;
      cand_rank  = pri_rank(cand_vec, lowest_q);
      isr_rank   = pri_rank(isr_q, lowest_q);
      eoi_rank   = pri_rank(eoi_vec, lowest_q);
      cand_lvl   = rank_lvl(cand_rank[2:0], lowest_q);
      eoi_ns_lvl = rank_lvl(eoi_rank[2:0], lowest_q);
      int_req_d  = !cand_rank[3] && (smm_act || (cand_rank < isr_rank));
   end

   // IRR/ISR update and INTA sequencing.
   // Ordering: EOI/AEOI clear, then setpri, then the INTA ISR set last so it wins.
   always_comb begin
      irr_d     = ltim ? ir_s : ((irr_q | ir_rise) & ir_s);
      isr_d     = isr_q;
      isr_set   = '0;
      lowest_d  = lowest_q;
      vec_lvl_d = vec_lvl_q;
      state_d   = state_q;
      if (eoi) begin
         if (eoi_spec) begin
            isr_d[eoi_lvl] = 1'b0;
            if (rot) lowest_d = eoi_lvl;
         end else if (!eoi_rank[3]) begin
            isr_d[eoi_ns_lvl] = 1'b0;
            if (rot) lowest_d = eoi_ns_lvl;
         end
      end
      case (state_q)
         ST_IDLE: begin
            if (inta_fall) begin
               state_d = ST_ACK1;
               if (!cand_rank[3]) begin
                  isr_set[cand_lvl] = 1'b1;
                  vec_lvl_d         = cand_lvl;
                  if (!ltim) irr_d[cand_lvl] = 1'b0;
               end else begin
                  vec_lvl_d = 3'd7;
               end
            end
         end
         ST_ACK1: begin
            if (inta_fall) begin
               state_d = ST_IDLE;
               if (aeoi) begin
                  isr_d[vec_lvl_q] = 1'b0;
                  if (rot) lowest_d = vec_lvl_q;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (setpri) lowest_d = eoi_lvl;
      isr_d = isr_d | isr_set;
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < SYNC_STAGES; i++) ir_sync_q[i] <= '0;
         inta_sync_q <= '0;
         ir_prev_q   <= '0;
         inta_prev_q <= 1'b0;
         irr_q       <= '0;
         isr_q       <= '0;
         int_req_q   <= 1'b0;
         vec_lvl_q   <= 3'd7;
         lowest_q    <= 3'd7;
         state_q     <= ST_IDLE;
      end else begin
         for (int unsigned i = 0; i < SYNC_STAGES; i++) ir_sync_q[i] <= ir_sync_d[i];
         inta_sync_q <= inta_sync_d;
         ir_prev_q   <= ir_prev_d;
         inta_prev_q <= inta_prev_d;
         irr_q       <= irr_d;
         isr_q       <= isr_d;
         int_req_q   <= int_req_d;
         vec_lvl_q   <= vec_lvl_d;
         lowest_q    <= lowest_d;
         state_q     <= state_d;
      end
   end

   assign irr      = irr_q;
   assign isr      = isr_q;
   assign int_req  = int_req_q;
   assign vec_lvl  = vec_lvl_q;
   assign ack_busy = (state_q == ST_ACK1);

endmodule

// File: tb/tb_pic_irr_priority.sv
// Scoreboard bench for pic_irr_priority: stimulus pushes expectations,
// a negedge monitor pops and compares them.
module tb_pic_irr_priority;

`ifdef PIC_SPECIAL_MASK_EN
   localparam logic SMM_ON = 1'b1;
`else
   localparam logic SMM_ON = 1'b0;
`endif

   localparam int unsigned S_IRR = 0, S_ISR = 1, S_INT = 2, S_VEC = 3, S_BUSY = 4;

   logic       clk = 1'b0;
   logic       rst_n, ltim, aeoi, rot, eoi, eoi_spec, setpri, smm, inta_n;
   logic [7:0] ir, mask;
   logic [2:0] eoi_lvl;
   logic [7:0] irr, isr;
   logic       int_req, ack_busy;
   logic [2:0] vec_lvl;

   pic_irr_priority #(.SYNC_STAGES(2)) dut (
      .clk(clk), .rst_n(rst_n), .ir(ir), .ltim(ltim), .mask(mask), .aeoi(aeoi),
      .rot(rot), .eoi(eoi), .eoi_spec(eoi_spec), .eoi_lvl(eoi_lvl), .setpri(setpri),
      .smm(smm), .inta_n(inta_n), .irr(irr), .isr(isr), .int_req(int_req),
      .vec_lvl(vec_lvl), .ack_busy(ack_busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int unsigned due;
      string       name;
      int unsigned sel;
      logic [7:0]  val;
   } snap_t;

   typedef struct {
      logic [2:0] lvl;
      logic [7:0] isr;
   } ack_t;

   snap_t       snapq[$];
   ack_t        ackq[$];
   int unsigned cyc = 0;
   int unsigned total = 0;
   int unsigned bad = 0;
   logic        ack_prev = 1'b0;
   snap_t       s;
   ack_t        a;
   logic [7:0]  act;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] sig(input int unsigned sel);
      case (sel)
         S_IRR:   sig = irr;
         S_ISR:   sig = isr;
         S_INT:   sig = {7'd0, int_req};
         S_VEC:   sig = {5'd0, vec_lvl};
         default: sig = {7'd0, ack_busy};
      endcase
   endfunction

   // Monitor: drains due snapshot checks and checks each new acknowledge.
   always @(negedge clk) begin
      while (snapq.size() != 0 && snapq[0].due <= cyc) begin
         s   = snapq.pop_front();
         act = sig(s.sel);
         total++;
         if (act !== s.val) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h (cycle %0d)", s.name, act, s.val, cyc);
         end
      end
      if (ack_busy === 1'b1 && !ack_prev) begin
         if (ackq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_ack: actual vec_lvl=%0d required no acknowledge", vec_lvl);
         end else begin
            a = ackq.pop_front();
            total++;
            if (vec_lvl !== a.lvl) begin
               bad++;
               $display("FAIL ack_vec: actual=%0d required=%0d", vec_lvl, a.lvl);
            end
            total++;
            if (isr !== a.isr) begin
               bad++;
               $display("FAIL ack_isr: actual=%h required=%h", isr, a.isr);
            end
         end
      end
      ack_prev = (ack_busy === 1'b1);
   end

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic clocks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_sig(input string name, input int unsigned sel, input logic [7:0] val);
      snap_t e;
      e.due  = cyc;
      e.name = name;
      e.sel  = sel;
      e.val  = val;
      snapq.push_back(e);
   endtask

   task automatic expect_ack(input logic [2:0] lvl, input logic [7:0] isr_v);
      ack_t e;
      e.lvl = lvl;
      e.isr = isr_v;
      ackq.push_back(e);
   endtask

   task automatic inta();
      inta_n = 1'b0;
      clocks(3);
      inta_n = 1'b1;
      clocks(3);
   endtask

   task automatic eoi_ns();
      eoi = 1'b1; eoi_spec = 1'b0;
      clocks(1);
      eoi = 1'b0;
   endtask

   task automatic eoi_sp(input logic [2:0] lvl);
      eoi = 1'b1; eoi_spec = 1'b1; eoi_lvl = lvl;
      clocks(1);
      eoi = 1'b0; eoi_spec = 1'b0;
   endtask

   task automatic set_pri(input logic [2:0] lvl);
      setpri = 1'b1; eoi_lvl = lvl;
      clocks(1);
      setpri = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; ir = '0; ltim = 1'b0; mask = '0; aeoi = 1'b0; rot = 1'b0;
      eoi = 1'b0; eoi_spec = 1'b0; eoi_lvl = '0; setpri = 1'b0; smm = 1'b0; inta_n = 1'b1;
      expect_sig("rst_irr", S_IRR, 8'h00);
      expect_sig("rst_isr", S_ISR, 8'h00);
      expect_sig("rst_int", S_INT, 8'h00);
      expect_sig("rst_vec", S_VEC, 8'h07);
      expect_sig("rst_busy", S_BUSY, 8'h00);
      clocks(2);
      rst_n = 1'b1;
      clocks(4);

      // Edge mode basic request, acknowledge and non-specific EOI
      ir = 8'h05;
      clocks(3);
      expect_sig("edge_irr", S_IRR, 8'h05);
      expect_sig("int_lat0", S_INT, 8'h00);
      clocks(1);
      expect_sig("int_lat1", S_INT, 8'h01);
      expect_ack(3'd0, 8'h01);
      inta();
      expect_sig("inta1_irr", S_IRR, 8'h04);
      expect_sig("inta1_busy", S_BUSY, 8'h01);
      expect_sig("nest_int", S_INT, 8'h00);
      inta();
      expect_sig("inta2_isr", S_ISR, 8'h01);
      expect_sig("inta2_busy", S_BUSY, 8'h00);
      eoi_ns();
      expect_sig("eoi_isr", S_ISR, 8'h00);
      expect_sig("eoi_int_old", S_INT, 8'h00);
      clocks(1);
      expect_sig("eoi_int_ir2", S_INT, 8'h01);
      expect_ack(3'd2, 8'h04);
      inta();
      expect_sig("ir2_irr", S_IRR, 8'h00);
      inta();
      eoi_ns();
      expect_sig("ir2_eoi", S_ISR, 8'h00);
      ir = 8'h00;
      clocks(4);

      // Edge mode: irr drops when the line falls
      ir = 8'h10;
      clocks(3);
      expect_sig("fall_set", S_IRR, 8'h10);
      ir = 8'h00;
      clocks(3);
      expect_sig("fall_clr", S_IRR, 8'h00);
      clocks(2);

      // Masking and set-priority
      mask = 8'h01;
      ir = 8'h81;
      clocks(3);
      expect_sig("mask_irr", S_IRR, 8'h81);
      clocks(1);
      expect_sig("mask_int", S_INT, 8'h01);
      expect_ack(3'd7, 8'h80);
      inta();
      expect_sig("mask_irr2", S_IRR, 8'h01);
      inta();
      eoi_ns();
      expect_sig("mask_eoi", S_ISR, 8'h00);
      set_pri(3'd6);
      mask = 8'h00;
      ir = 8'h00;
      clocks(3);
      ir = 8'hC1;
      clocks(3);
      expect_sig("pri_irr", S_IRR, 8'hC1);
      clocks(1);
      expect_ack(3'd7, 8'h80);
      inta();
      expect_sig("pri_irr2", S_IRR, 8'h41);
      inta();
      eoi_ns();
      expect_sig("pri_eoi7", S_ISR, 8'h00);
      expect_ack(3'd0, 8'h01);
      inta();
      expect_sig("pri_irr3", S_IRR, 8'h40);
      inta();
      eoi_sp(3'd0);
      expect_sig("spec_eoi", S_ISR, 8'h00);
      set_pri(3'd7);
      ir = 8'h00;
      clocks(4);
      expect_sig("pri_done", S_IRR, 8'h00);

      // Level mode with automatic rotation and AEOI
      ltim = 1'b1; rot = 1'b1; aeoi = 1'b1;
      ir = 8'h03;
      clocks(3);
      expect_sig("lvl_irr", S_IRR, 8'h03);
      for (int k = 0; k < 4; k++) begin
         logic [2:0] lv;
         lv = (k % 2 == 0) ? 3'd0 : 3'd1;
         expect_ack(lv, 8'h01 << lv);
         inta();
         expect_sig("rot_irr", S_IRR, 8'h03);
         inta();
         expect_sig("rot_isr", S_ISR, 8'h00);
      end
      rot = 1'b0; aeoi = 1'b0;
      set_pri(3'd7);
      ir = 8'h00;
      clocks(3);
      expect_sig("lvl_clr", S_IRR, 8'h00);
      ltim = 1'b0;
      clocks(2);

      // Nesting, spurious acknowledge and reset during acknowledge
      ir = 8'h02;
      clocks(4);
      expect_ack(3'd1, 8'h02);
      inta();
      inta();
      expect_sig("nest_isr", S_ISR, 8'h02);
      ir = 8'h0A;
      clocks(3);
      expect_sig("nest_irr3", S_IRR, 8'h08);
      clocks(1);
      expect_sig("nest_blk", S_INT, 8'h00);
      ir = 8'h0B;
      clocks(3);
      expect_sig("nest_irr0", S_IRR, 8'h09);
      clocks(1);
      expect_sig("nest_ir0", S_INT, 8'h01);
      mask = 8'hFF;
      clocks(1);
      expect_sig("mask_all", S_INT, 8'h00);
      expect_ack(3'd7, 8'h02);
      inta_n = 1'b0;
      clocks(3);
      expect_sig("spur_busy", S_BUSY, 8'h01);
      expect_sig("spur_irr", S_IRR, 8'h09);
      clocks(1);
      rst_n = 1'b0;
      expect_sig("arst_irr", S_IRR, 8'h00);
      expect_sig("arst_isr", S_ISR, 8'h00);
      expect_sig("arst_busy", S_BUSY, 8'h00);
      expect_sig("arst_vec", S_VEC, 8'h07);
      expect_sig("arst_int", S_INT, 8'h00);
      inta_n = 1'b1; ir = 8'h00; mask = 8'h00;
      clocks(2);
      rst_n = 1'b1;
      clocks(4);

      // Special mask mode (only effective when the feature is built in)
      ir = 8'h02;
      clocks(4);
      expect_ack(3'd1, 8'h02);
      inta();
      inta();
      mask = 8'h02; smm = 1'b1;
      ir = 8'h0A;
      clocks(3);
      expect_sig("smm_irr", S_IRR, 8'h08);
      clocks(1);
      expect_sig("smm_int", S_INT, SMM_ON ? 8'h01 : 8'h00);
      eoi_ns();
      expect_sig("smm_eoi", S_ISR, SMM_ON ? 8'h02 : 8'h00);
      clocks(5);

      total++;
      if (ackq.size() != 0) begin
         bad++;
         $display("FAIL ack_pending: actual=%0d outstanding required=0", ackq.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
